fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that succeeds the single-PC fetch stage. It issues sequential fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses of arbitrary latency. It holds up to DEPTH instructions in flight or buffered, and presents {pc, insn} pairs to decode over a valid/ready channel. A redirect input (branch/jump) flushes the queue and discards stale responses.

---
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: memory request/response channels, redirect, and decode output channel.
// Signal suffixes are relative to the fetch_queue (master) side.
interface fetch_queue_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
);
    logic              req_valid_o;
    logic [AWIDTH-1:0] req_addr_o;
    logic              req_ready_i;
    logic              rsp_valid_i;
    logic [DWIDTH-1:0] rsp_data_i;
    logic              redirect_i;
    logic [AWIDTH-1:0] redirect_pc_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;

    modport master (
        output req_valid_o, req_addr_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i,
        input  redirect_i, redirect_pc_i,
        output out_valid_o, pc_o, insn_o,
        input  out_ready_i
    );

    modport slave (
        input  req_valid_o, req_addr_o,
        output req_ready_i, rsp_valid_i, rsp_data_i,
        output redirect_i, redirect_pc_i,
        input  out_valid_o, pc_o, insn_o,
        output out_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch over valid/ready, in-order responses, ring buffer to decode.
// Optional FETCH_PERF_EN adds retired/dropped performance counters.
module fetch_queue #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int unsigned       DEPTH    = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_retired_o,
    output logic [31:0]  perf_dropped_o
`endif
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned DROPW = 16;

    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] slot_addr [DEPTH];
    logic [DWIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0]  slot_filled;
    logic [DEPTH-1:0]  filled_next;
    logic [PW-1:0]     alloc_ptr;
    logic [PW-1:0]     fill_ptr;
    logic [PW-1:0]     retire_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     pend;
    logic [DROPW-1:0]  drop;

    logic req_valid;
    logic req_fire;
    logic rsp_fill;
    logic rsp_discard;
    logic out_valid;
    logic out_fire;
    logic unused_redirect_low;

    assign unused_redirect_low = ^bus.redirect_pc_i[1:0];

    assign req_valid = rst && (count < CW'(DEPTH)) && !bus.redirect_i;
    assign req_fire  = req_valid && bus.req_ready_i;
    assign out_valid = slot_filled[retire_ptr];
    assign out_fire  = out_valid && bus.out_ready_i && !bus.redirect_i;

    // A redirect-cycle response is discarded; it only counts against drop if something was outstanding.
    assign rsp_fill    = bus.rsp_valid_i && !bus.redirect_i && (drop == '0) && (pend != '0);
    assign rsp_discard = bus.rsp_valid_i &&
                         (bus.redirect_i ? ((drop != '0) || (pend != '0)) : (drop != '0));

    assign bus.req_valid_o = req_valid;
    assign bus.req_addr_o  = pc;
    assign bus.out_valid_o = out_valid;
    assign bus.pc_o        = out_valid ? slot_addr[retire_ptr] : '0;
    assign bus.insn_o      = out_valid ? slot_data[retire_ptr] : '0;

    always_comb begin
        filled_next = slot_filled;
        if (req_fire) filled_next[alloc_ptr]  = 1'b0;
        if (rsp_fill) filled_next[fill_ptr]   = 1'b1;
        if (out_fire) filled_next[retire_ptr] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= BASEADDR;
            slot_filled <= '0;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            retire_ptr  <= '0;
            count       <= '0;
            pend        <= '0;
            drop        <= '0;
        end else if (bus.redirect_i) begin
            pc          <= {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
            slot_filled <= '0;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            retire_ptr  <= '0;
            count       <= '0;
            pend        <= '0;
            drop        <= drop + DROPW'(pend) - DROPW'(rsp_discard);
        end else begin
            slot_filled <= filled_next;
            if (req_fire) begin
                alloc_ptr <= alloc_ptr + 1'b1;
                pc        <= pc + AWIDTH'(4);
            end
            if (rsp_fill)    fill_ptr   <= fill_ptr + 1'b1;
            if (out_fire)    retire_ptr <= retire_ptr + 1'b1;
            if (rsp_discard) drop       <= drop - 1'b1;
            count <= count + CW'(req_fire) - CW'(out_fire);
            pend  <= pend + CW'(req_fire) - CW'(rsp_fill);
        end
    end

    // Slot payload needs no reset: it is only visible when the matching filled bit is set.
    always_ff @(posedge clk) begin
        if (req_fire) slot_addr[alloc_ptr] <= pc;
        if (rsp_fill) slot_data[fill_ptr]  <= bus.rsp_data_i;
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_retired_o <= '0;
            perf_dropped_o <= '0;
        end else begin
            if (out_fire)    perf_retired_o <= perf_retired_o + 32'd1;
            if (rsp_discard) perf_dropped_o <= perf_dropped_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue with a fixed-latency in-order memory model.
module tb_fetch_queue;
    logic clk;
    logic rst;

    fetch_queue_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_dropped;
`endif

    fetch_queue #(
        .DWIDTH(32),
        .AWIDTH(32),
        .BASEADDR(32'h0100_0000),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_retired_o(perf_retired),
        .perf_dropped_o(perf_dropped)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] req_log[$];
    logic [31:0] out_pc[$];
    logic [31:0] out_insn[$];
    int          out_cyc[$];
    int          cyc;
    int          lat;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(logic [31:0] addr);
        return {addr[15:0], 16'hC0DE};
    endfunction

    function automatic logic [31:0] pc_at(int i);
        return (i < out_pc.size()) ? out_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] insn_at(int i);
        return (i < out_insn.size()) ? out_insn[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int cyc_at(int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -1;
    endfunction

    function automatic logic [31:0] req_at(int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        out_pc.delete();
        out_insn.delete();
        out_cyc.delete();
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.rsp_valid_i = 1'b1;
            bus.rsp_data_i  = insn_of(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            bus.rsp_valid_i = 1'b0;
            bus.rsp_data_i  = '0;
        end
        #1;
        if (bus.req_valid_o && bus.req_ready_i) begin
            memq.push_back('{addr: bus.req_addr_o, due: cyc + lat});
            req_log.push_back(bus.req_addr_o);
        end
        if (bus.out_valid_o && bus.out_ready_i && !bus.redirect_i) begin
            out_pc.push_back(bus.pc_o);
            out_insn.push_back(bus.insn_o);
            out_cyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_outputs(input int n, input int budget, input string tag);
        int b;
        b = budget;
        while (out_pc.size() < n && b > 0) begin
            tick();
            b--;
        end
        check({tag, "_outputs_seen"}, 64'(out_pc.size() >= n), 64'd1);
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        bus.redirect_i  = 1'b0;
        bus.rsp_valid_i = 1'b0;
        bus.rsp_data_i  = '0;
        memq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        clear_logs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        lat      = 1;
        rst              = 1'b0;
        bus.req_ready_i  = 1'b1;
        bus.rsp_valid_i  = 1'b0;
        bus.rsp_data_i   = '0;
        bus.redirect_i   = 1'b0;
        bus.redirect_pc_i = '0;
        bus.out_ready_i  = 1'b1;

        // Reset hold and release
        repeat (2) @(negedge clk);
        check("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_pc", 64'(bus.pc_o), 64'd0);
        check("rst_insn", 64'(bus.insn_o), 64'd0);
        rst = 1'b1;
        cyc = 0;
        clear_logs();
        #1;
        check("rel_req_valid", 64'(bus.req_valid_o), 64'd1);
        check("rel_req_addr", 64'(bus.req_addr_o), 64'h0100_0000);

        // Streaming, 1-cycle memory
        lat = 1;
        bus.out_ready_i = 1'b1;
        bus.req_ready_i = 1'b1;
        run_until_outputs(3, 20, "stream");
        check("stream_pc0", 64'(pc_at(0)), 64'h0100_0000);
        check("stream_insn0", 64'(insn_at(0)), 64'h0000_C0DE);
        check("stream_pc1", 64'(pc_at(1)), 64'h0100_0004);
        check("stream_insn1", 64'(insn_at(1)), 64'h0004_C0DE);
        check("stream_pc2", 64'(pc_at(2)), 64'h0100_0008);
        check("stream_insn2", 64'(insn_at(2)), 64'h0008_C0DE);
        check("stream_first_cyc", 64'(cyc_at(0)), 64'd2);
        check("stream_gap01", 64'(cyc_at(1) - cyc_at(0)), 64'd1);
        check("stream_gap12", 64'(cyc_at(2) - cyc_at(1)), 64'd1);

        // Backpressure: queue fills to DEPTH, then drains in order
        do_reset();
        lat = 1;
        bus.out_ready_i = 1'b0;
        repeat (10) tick();
        check("bp_req_count", 64'(req_log.size()), 64'd4);
        check("bp_req_valid", 64'(bus.req_valid_o), 64'd0);
        check("bp_last_req", 64'(req_at(3)), 64'h0100_000C);
        check("bp_head_pc", 64'(bus.pc_o), 64'h0100_0000);
        check("bp_head_insn", 64'(bus.insn_o), 64'h0000_C0DE);
        bus.out_ready_i = 1'b1;
        run_until_outputs(4, 20, "bp");
        check("bp_pc0", 64'(pc_at(0)), 64'h0100_0000);
        check("bp_pc1", 64'(pc_at(1)), 64'h0100_0004);
        check("bp_pc2", 64'(pc_at(2)), 64'h0100_0008);
        check("bp_pc3", 64'(pc_at(3)), 64'h0100_000C);
        begin
            int b;
            b = 10;
            while (req_log.size() < 5 && b > 0) begin
                tick();
                b--;
            end
        end
        check("bp_resume_addr", 64'(req_at(4)), 64'h0100_0010);

        // Redirect with two requests outstanding on slow memory
        do_reset();
        lat = 4;
        bus.out_ready_i = 1'b1;
        bus.req_ready_i = 1'b1;
        repeat (2) tick();
        bus.req_ready_i = 1'b0;
        tick();
        check("rd_outstanding", 64'(req_log.size()), 64'd2);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_2000;
        tick();
        bus.redirect_i  = 1'b0;
        bus.req_ready_i = 1'b1;
        run_until_outputs(1, 30, "rd");
        check("rd_req_target", 64'(req_at(2)), 64'h0000_2000);
        check("rd_pc", 64'(pc_at(0)), 64'h0000_2000);
        check("rd_insn", 64'(insn_at(0)), 64'h2000_C0DE);
        check("rd_out_cyc", 64'(cyc_at(0)), 64'd9);
`ifdef FETCH_PERF_EN
        check("rd_perf_dropped", 64'(perf_dropped), 64'd2);
        check("rd_perf_retired", 64'(perf_retired), 64'd1);
`endif

        // Misaligned redirect coincident with a response; output handshake that cycle ignored
        do_reset();
        lat = 1;
        bus.out_ready_i = 1'b1;
        bus.req_ready_i = 1'b1;
        repeat (4) tick();
        clear_logs();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_2003;
        tick();
        bus.redirect_i = 1'b0;
        #1;
        check("mis_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("mis_req_valid", 64'(bus.req_valid_o), 64'd1);
        check("mis_req_addr", 64'(bus.req_addr_o), 64'h0000_2000);
        run_until_outputs(1, 20, "mis");
        check("mis_pc", 64'(pc_at(0)), 64'h0000_2000);
        check("mis_insn", 64'(insn_at(0)), 64'h2000_C0DE);
        check("mis_out_cyc", 64'(cyc_at(0)), 64'd7);
`ifdef FETCH_PERF_EN
        check("mis_perf_dropped", 64'(perf_dropped), 64'd1);
        check("mis_perf_retired", 64'(perf_retired), 64'd3);
`endif

        // Asynchronous reset mid-stream with three slots filled
        do_reset();
        lat = 1;
        bus.out_ready_i = 1'b0;
        bus.req_ready_i = 1'b1;
        repeat (4) tick();
        check("ar_pre_valid", 64'(bus.out_valid_o), 64'd1);
        check("ar_pre_pc", 64'(bus.pc_o), 64'h0100_0000);
        @(posedge clk);
        #2;
        rst             = 1'b0;
        bus.rsp_valid_i = 1'b0;
        memq.delete();
        #1;
        check("ar_req_valid", 64'(bus.req_valid_o), 64'd0);
        check("ar_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("ar_pc", 64'(bus.pc_o), 64'd0);
        check("ar_insn", 64'(bus.insn_o), 64'd0);
`ifdef FETCH_PERF_EN
        check("ar_perf_retired", 64'(perf_retired), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        clear_logs();
        #1;
        check("ar_restart_addr", 64'(bus.req_addr_o), 64'h0100_0000);
        bus.out_ready_i = 1'b1;
        run_until_outputs(1, 10, "ar");
        check("ar_restart_pc", 64'(pc_at(0)), 64'h0100_0000);
        check("ar_restart_insn", 64'(insn_at(0)), 64'h0000_C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
